scmi_irq_ctrl: RTL and testbench

// Interrupt conditioner downstream of the SCMI mailbox register file. It consumes the level

---
 rtl/scmi_irq_ctrl_pkg.sv | 7 +
 rtl/scmi_irq_ctrl_if.sv | 15 +
 rtl/scmi_irq_ctrl_chan.sv | 79 +++++++
 rtl/scmi_irq_ctrl.sv | 31 +++
 tb/tb_scmi_irq_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/scmi_irq_ctrl_pkg.sv
// scmi_irq_pkg: shared channel state type and timer sizing helper
package scmi_irq_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, TIMEOUT} chan_state_e;
  function automatic int timer_w(int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction
endpackage

// File: rtl/scmi_irq_ctrl_if.sv
// scmi_irq_ctrl_if: mailbox/core side bundle of the interrupt conditioner
interface scmi_irq_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       src_i;
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       ack_i;
  logic [NUM_CH-1:0]       irq_o;
  logic [NUM_CH-1:0]       timeout_o;
  logic [NUM_CH-1:0]       coalesced_o;
  logic [NUM_CH*CNT_W-1:0] evt_cnt_o;
  modport master (output src_i, en_i, ack_i, input irq_o, timeout_o, coalesced_o, evt_cnt_o);
  modport slave  (input src_i, en_i, ack_i, output irq_o, timeout_o, coalesced_o, evt_cnt_o);
endinterface

// File: rtl/scmi_irq_ctrl_chan.sv
// scmi_irq_chan: one channel of edge detect, FSM, watchdog, event counter and sticky flags
module scmi_irq_chan
  import scmi_irq_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit PULSE_MODE     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_src,
  input  logic             i_en,
  input  logic             i_ack,
  output logic             o_irq,
  output logic             o_timeout,
  output logic             o_coalesced,
  output logic [CNT_W-1:0] o_evt_cnt
);
  localparam int TW = timer_w(TIMEOUT_CYCLES);
  chan_state_e      r_state;
  logic             r_src_q, r_irq, r_timeout, r_coalesced;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;
  logic [CNT_W-1:0] w_cnt_inc;
  assign w_edge    = i_src & ~r_src_q;
  assign w_cnt_inc = r_cnt + CNT_W'(~&r_cnt);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_src_q     <= 1'b0;
      r_irq       <= 1'b0;
      r_timeout   <= 1'b0;
      r_coalesced <= 1'b0;
      r_timer     <= '0;
      r_cnt       <= '0;
    end else begin
      r_src_q <= i_src;
      if (!i_en) begin
        r_state     <= IDLE;
        r_timer     <= '0;
        r_timeout   <= 1'b0;
        r_coalesced <= 1'b0;
        r_irq       <= 1'b0;
      end else if (r_state == IDLE) begin
        r_irq <= w_edge;
        if (w_edge) begin
          r_state <= PENDING;
          r_timer <= '0;
          r_cnt   <= w_cnt_inc;
        end
      end else if (i_ack) begin
        // an edge coinciding with ack re-arms the request instead of coalescing
        r_state     <= w_edge ? PENDING : IDLE;
        r_timer     <= '0;
        r_timeout   <= 1'b0;
        r_coalesced <= 1'b0;
        r_irq       <= w_edge;
        if (w_edge) r_cnt <= w_cnt_inc;
      end else begin
        r_irq <= !PULSE_MODE;
        if (w_edge) begin
          r_coalesced <= 1'b1;
          r_cnt       <= w_cnt_inc;
        end
        if (r_state == PENDING && TIMEOUT_CYCLES != 0) begin
          if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= TIMEOUT;
            r_timeout <= 1'b1;
          end else r_timer <= r_timer + TW'(1);
        end
      end
    end
  end
  assign o_irq       = r_irq;
  assign o_timeout   = r_timeout;
  assign o_coalesced = r_coalesced;
  assign o_evt_cnt   = r_cnt;
endmodule

// File: rtl/scmi_irq_ctrl.sv
// scmi_irq_ctrl: per-channel interrupt conditioner for SCMI doorbell (ch0) and completion (ch1) bits
module scmi_irq_ctrl
  import scmi_irq_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit PULSE_MODE     = 1'b0
) (
  input logic           clk_i,
  input logic           rst_i,
  scmi_irq_ctrl_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    scmi_irq_chan #(
      .CNT_W(CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .PULSE_MODE(PULSE_MODE)
    ) u_chan (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .i_src(bus.src_i[i]),
      .i_en(bus.en_i[i]),
      .i_ack(bus.ack_i[i]),
      .o_irq(bus.irq_o[i]),
      .o_timeout(bus.timeout_o[i]),
      .o_coalesced(bus.coalesced_o[i]),
      .o_evt_cnt(bus.evt_cnt_o[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_scmi_irq_ctrl.sv
// tb_scmi_irq_ctrl: directed checks of level (a), pulse (b) and no-watchdog (c) variants
module tb_scmi_irq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] src, en, ack;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  scmi_irq_ctrl_if #(.NUM_CH(2), .CNT_W(4)) if_a ();
  scmi_irq_ctrl_if #(.NUM_CH(2), .CNT_W(4)) if_b ();
  scmi_irq_ctrl_if #(.NUM_CH(2), .CNT_W(4)) if_c ();
  assign if_a.src_i = src;
  assign if_a.en_i  = en;
  assign if_a.ack_i = ack;
  assign if_b.src_i = src;
  assign if_b.en_i  = en;
  assign if_b.ack_i = ack;
  assign if_c.src_i = src;
  assign if_c.en_i  = en;
  assign if_c.ack_i = ack;
  scmi_irq_ctrl #(.NUM_CH(2), .CNT_W(4), .TIMEOUT_CYCLES(8), .PULSE_MODE(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a.slave));
  scmi_irq_ctrl #(.NUM_CH(2), .CNT_W(4), .TIMEOUT_CYCLES(8), .PULSE_MODE(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b.slave));
  scmi_irq_ctrl #(.NUM_CH(2), .CNT_W(4), .TIMEOUT_CYCLES(0), .PULSE_MODE(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(if_c.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; src = 2'b00; en = 2'b00; ack = 2'b00;
    tick(); tick();
    chk("rst_irq_a", 32'(if_a.irq_o), 0);
    chk("rst_cnt_a", 32'(if_a.evt_cnt_o), 0);
    chk("rst_flags_b", 32'({if_b.timeout_o, if_b.coalesced_o, if_b.irq_o}), 0);
    // T1 basic
    rst = 1'b0; en = 2'b11;
    tick();
    src[0] = 1'b1;
    tick();
    chk("t1_irq_a", 32'(if_a.irq_o), 1);
    chk("t1_irq_b", 32'(if_b.irq_o), 1);
    chk("t1_cnt_a", 32'(if_a.evt_cnt_o[3:0]), 1);
    tick();
    chk("t1_hold_irq_a", 32'(if_a.irq_o), 1);
    chk("t1_pulse_end_b", 32'(if_b.irq_o), 0);
    tick(); tick();
    chk("t1_no_refire_cnt", 32'(if_a.evt_cnt_o[3:0]), 1);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("t1_ack_irq_a", 32'(if_a.irq_o), 0);
    chk("t1_ack_cnt_a", 32'(if_a.evt_cnt_o[3:0]), 1);
    // T2 timeout after 8 cycles pending
    src[0] = 1'b0;
    tick();
    src[0] = 1'b1;
    tick();
    chk("t2_irq_a", 32'(if_a.irq_o), 1);
    repeat (7) tick();
    chk("t2_no_to_yet", 32'(if_a.timeout_o), 0);
    tick();
    chk("t2_to_a", 32'(if_a.timeout_o), 1);
    chk("t2_irq_held_a", 32'(if_a.irq_o), 1);
    chk("t2_to_b", 32'(if_b.timeout_o), 1);
    chk("t2_to_c_disabled", 32'(if_c.timeout_o), 0);
    chk("t2_irq_c", 32'(if_c.irq_o), 1);
    tick(); tick();
    chk("t2_to_sticky", 32'(if_a.timeout_o), 1);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("t2_ack_irq_to", 32'({if_a.timeout_o, if_a.irq_o}), 0);
    chk("t2_cnt_a", 32'(if_a.evt_cnt_o[3:0]), 2);
    // T3 coalesce
    src[0] = 1'b0;
    tick();
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    tick();
    chk("t3_no_coal_yet", 32'(if_a.coalesced_o), 0);
    src[0] = 1'b1;
    tick();
    chk("t3_coal_a", 32'(if_a.coalesced_o), 1);
    chk("t3_cnt_a", 32'(if_a.evt_cnt_o[3:0]), 4);
    chk("t3_irq_a", 32'(if_a.irq_o), 1);
    chk("t3_cnt_c", 32'(if_c.evt_cnt_o[3:0]), 4);
    // T4 edge with ack in PENDING re-arms
    src[0] = 1'b0;
    tick();
    src[0] = 1'b1; ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("t4_irq_a", 32'(if_a.irq_o), 1);
    chk("t4_refire_b", 32'(if_b.irq_o), 1);
    chk("t4_coal_clr", 32'(if_a.coalesced_o), 0);
    chk("t4_cnt_a", 32'(if_a.evt_cnt_o[3:0]), 5);
    tick();
    chk("t4_pulse_end_b", 32'(if_b.irq_o), 0);
    repeat (6) tick();
    chk("t4_timer_restart", 32'(if_a.timeout_o), 0);
    tick();
    chk("t4_to_a", 32'(if_a.timeout_o), 1);
    // T5 disable while TIMEOUT, then reset mid-PENDING
    en[0] = 1'b0;
    tick();
    chk("t5_dis_flags", 32'({if_a.timeout_o, if_a.coalesced_o, if_a.irq_o}), 0);
    chk("t5_dis_cnt", 32'(if_a.evt_cnt_o[3:0]), 5);
    en[0] = 1'b1;
    tick();
    chk("t5_held_no_edge", 32'(if_a.irq_o), 0);
    src[0] = 1'b0;
    tick();
    src[0] = 1'b1;
    tick();
    chk("t5_pend_cnt", 32'(if_a.evt_cnt_o[3:0]), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_irq", 32'(if_a.irq_o), 0);
    chk("t5_rst_cnt", 32'(if_a.evt_cnt_o), 0);
    tick();
    chk("t5_src_at_release", 32'({if_a.evt_cnt_o[3:0], 3'b000, if_a.irq_o[0]}), 32'h11);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0; src[0] = 1'b0;
    tick();
    chk("t5_ack_irq", 32'(if_a.irq_o), 0);
    // T6 saturation on ch1, ch0 untouched
    for (int k = 0; k < 20; k++) begin
      src[1] = 1'b1;
      tick();
      src[1] = 1'b0; ack[1] = 1'b1;
      tick();
      ack[1] = 1'b0;
    end
    chk("t6_sat_cnt1_a", 32'(if_a.evt_cnt_o[7:4]), 15);
    chk("t6_sat_cnt1_b", 32'(if_b.evt_cnt_o[7:4]), 15);
    chk("t6_ch1_idle", 32'(if_a.irq_o[1]), 0);
    chk("t6_ch0_cnt", 32'(if_a.evt_cnt_o[3:0]), 1);
    chk("t6_ch0_flags", 32'({if_a.timeout_o[0], if_a.coalesced_o[0], if_a.irq_o[0]}), 0);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("t6_ack_in_idle", 32'({if_a.evt_cnt_o[3:0], 3'b000, if_a.irq_o[0]}), 32'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
